// File: rtl/msg_uart_streamer.sv
// Fixed-message 8N1 UART transmitter with one-shot and repeat modes.
// Bytes go out first-to-last; repeat mode inserts a programmable idle gap between messages.
module msg_uart_streamer #(
  parameter int unsigned           MSG_LEN      = 13,
  parameter logic [8*MSG_LEN-1:0]  MSG          = "Hello world!\n",
  parameter int unsigned           CLKS_PER_BIT = 868,
  parameter int unsigned           GAP_CYCLES   = 95969,
  localparam int unsigned          IW           = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          repeat_mode,
  output logic          txd,
  output logic [7:0]    word,
  output logic          transmit_ready,
  output logic          busy,
  output logic          msg_done,
  output logic [IW-1:0] char_idx
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  localparam int unsigned GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST = IW'(MSG_LEN - 1);

  // Ascending byte order so element 0 is the first character sent.
  localparam logic [0:MSG_LEN-1][7:0] MSG_BYTES = MSG;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_GAP
  } state_e;

  state_e        state_q;
  logic [TW-1:0] timer_q;
  logic [2:0]    bit_q;
  logic [GW-1:0] gap_q;
  logic          en_q;
  logic          txd_q;
  logic [7:0]    word_q;
  logic          ready_q;
  logic          busy_q;
  logic          done_q;
  logic [IW-1:0] idx_q;

  logic          timer_end_d;
  logic          start_d;
  logic [IW-1:0] next_idx_d;
  logic [7:0]    next_byte_d;

  assign timer_end_d = (timer_q == BIT_LAST);
  // One-shot mode needs a fresh rising edge of en; repeat mode runs on the level.
  assign start_d     = repeat_mode ? en : (en & ~en_q);
  assign next_idx_d  = idx_q + IW'(1);
  assign next_byte_d = MSG_BYTES[next_idx_d];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      en_q    <= 1'b0;
      txd_q   <= 1'b1;
      word_q  <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      en_q   <= en;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_d) begin
            state_q <= S_START;
            timer_q <= '0;
            idx_q   <= '0;
            word_q  <= MSG_BYTES[0];
            txd_q   <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end

        S_START: begin
          if (timer_end_d) begin
            state_q <= S_DATA;
            timer_q <= '0;
            bit_q   <= '0;
            txd_q   <= word_q[0];
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end

        S_DATA: begin
          if (timer_end_d) begin
            timer_q <= '0;
            if (bit_q == 3'd7) begin
              state_q <= S_STOP;
              txd_q   <= 1'b1;
            end else begin
              bit_q <= bit_q + 3'd1;
              txd_q <= word_q[bit_q + 3'd1];
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end

        S_STOP: begin
          if (timer_end_d) begin
            timer_q <= '0;
            // Disable only takes effect here, so frames are never cut short.
            if (!en) begin
              state_q <= S_IDLE;
              idx_q   <= '0;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
            end else if (idx_q < IDX_LAST) begin
              state_q <= S_START;
              idx_q   <= next_idx_d;
              word_q  <= next_byte_d;
              txd_q   <= 1'b0;
            end else begin
              done_q <= 1'b1;
              idx_q  <= '0;
              if (repeat_mode) begin
                if (GAP_CYCLES == 0) begin
                  state_q <= S_START;
                  word_q  <= MSG_BYTES[0];
                  txd_q   <= 1'b0;
                end else begin
                  state_q <= S_GAP;
                  gap_q   <= '0;
                  ready_q <= 1'b1;
                end
              end else begin
                state_q <= S_IDLE;
                ready_q <= 1'b1;
                busy_q  <= 1'b0;
              end
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end

        S_GAP: begin
          if (!en) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (gap_q == GAP_LAST) begin
            state_q <= S_START;
            gap_q   <= '0;
            timer_q <= '0;
            idx_q   <= '0;
            word_q  <= MSG_BYTES[0];
            txd_q   <= 1'b0;
            ready_q <= 1'b0;
          end else begin
            gap_q <= gap_q + GW'(1);
          end
        end

        default: begin
          state_q <= S_IDLE;
          txd_q   <= 1'b1;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign txd            = txd_q;
  assign word           = word_q;
  assign transmit_ready = ready_q;
  assign busy           = busy_q;
  assign msg_done       = done_q;
  assign char_idx       = idx_q;

endmodule

// File: tb/tb_msg_uart_streamer.sv
// Directed bench for msg_uart_streamer: "Hi\n" at 4 clocks/bit with a 5-cycle gap,
// plus a single-byte, zero-gap instance for back-to-back repeat framing.
module tb_msg_uart_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       en;
  logic       repeat_mode;
  logic       txd;
  logic [7:0] word;
  logic       ready;
  logic       busy;
  logic       done;
  logic [1:0] idx;

  logic       en1;
  logic       rep1;
  logic       txd1;
  logic [7:0] word1;
  logic       ready1;
  logic       busy1;
  logic       done1;
  logic [0:0] idx1;

  int checks   = 0;
  int failures = 0;

  logic [7:0] msg_tab [0:2] = '{8'h48, 8'h69, 8'h0A};

  msg_uart_streamer #(
    .MSG_LEN(3), .MSG("Hi\n"), .CLKS_PER_BIT(4), .GAP_CYCLES(5)
  ) u_dut (
    .clk(clk), .rst(rst), .en(en), .repeat_mode(repeat_mode),
    .txd(txd), .word(word), .transmit_ready(ready), .busy(busy),
    .msg_done(done), .char_idx(idx)
  );

  msg_uart_streamer #(
    .MSG_LEN(1), .MSG(8'h41), .CLKS_PER_BIT(4), .GAP_CYCLES(0)
  ) u_dut1 (
    .clk(clk), .rst(rst), .en(en1), .repeat_mode(rep1),
    .txd(txd1), .word(word1), .transmit_ready(ready1), .busy(busy1),
    .msg_done(done1), .char_idx(idx1)
  );

  // Expected line level for one of the ten bit slots of an 8N1 frame.
  function automatic logic exp_bit(input logic [7:0] b, input int slot);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    f = f >> slot;
    return f[0];
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b0; repeat_mode = 1'b0; en1 = 1'b0; rep1 = 1'b1;
    @(negedge clk);
    checks++;
    if ({txd, word, ready, busy, done, idx} !== {1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 2'd0}) begin
      failures++;
      $display("FAIL reset_values got txd=%b word=%h rdy=%b busy=%b done=%b idx=%0d", txd, word, ready, busy, done, idx);
    end
    rst = 1'b1;
    repeat (3) step();
    en = 1'b1;
    repeat (7) step();
    checks++;
    if (busy !== 1'b1 || txd !== 1'b0 || word !== 8'h48) begin
      failures++;
      $display("FAIL reset_pre_data got busy=%b txd=%b word=%h exp busy=1 txd=0 word=48", busy, txd, word);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({txd, word, ready, busy, done, idx} !== {1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 2'd0}) begin
      failures++;
      $display("FAIL reset_async got txd=%b word=%h rdy=%b busy=%b done=%b idx=%0d", txd, word, ready, busy, done, idx);
    end
    en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (5) step();
    checks++;
    if (busy !== 1'b0 || txd !== 1'b1 || ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_idle got busy=%b txd=%b rdy=%b exp 0 1 1", busy, txd, ready);
    end
  endtask

  task automatic test_oneshot();
    int pulses;
    pulses = 0;
    repeat_mode = 1'b0;
    en = 1'b1;
    for (int t = 0; t <= 180; t++) begin
      step();
      if (done === 1'b1) pulses++;
      if (t < 120 && t % 4 == 1) begin
        checks++;
        if (txd !== exp_bit(msg_tab[t / 40], (t % 40) / 4)) begin
          failures++;
          $display("FAIL oneshot_txd t=%0d got=%b exp=%b", t, txd, exp_bit(msg_tab[t / 40], (t % 40) / 4));
        end
      end
      if (t < 120 && t % 40 == 1) begin
        checks++;
        if (idx !== 2'(t / 40) || word !== msg_tab[t / 40]) begin
          failures++;
          $display("FAIL oneshot_byte t=%0d got idx=%0d word=%h exp idx=%0d word=%h", t, idx, word, t / 40, msg_tab[t / 40]);
        end
      end
      if (t == 0) begin
        checks++;
        if (ready !== 1'b0 || busy !== 1'b1) begin
          failures++;
          $display("FAIL oneshot_start got rdy=%b busy=%b exp 0 1", ready, busy);
        end
      end
      if (t == 120) begin
        checks++;
        if (done !== 1'b1 || ready !== 1'b1 || busy !== 1'b0 || idx !== 2'd0) begin
          failures++;
          $display("FAIL oneshot_end got done=%b rdy=%b busy=%b idx=%0d exp 1 1 0 0", done, ready, busy, idx);
        end
      end
      if (t > 120 && t % 20 == 0) begin
        checks++;
        if (txd !== 1'b1 || busy !== 1'b0) begin
          failures++;
          $display("FAIL oneshot_no_restart t=%0d got txd=%b busy=%b exp 1 0", t, txd, busy);
        end
      end
    end
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("FAIL oneshot_pulses got=%0d exp=1", pulses);
    end
    en = 1'b0;
    step();
    en = 1'b1;
    step();
    checks++;
    if (txd !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL oneshot_reedge got txd=%b busy=%b exp 0 1", txd, busy);
    end
    en = 1'b0;
    repeat (45) step();
    checks++;
    if (busy !== 1'b0 || idx !== 2'd0) begin
      failures++;
      $display("FAIL oneshot_cleanup got busy=%b idx=%0d exp 0 0", busy, idx);
    end
  endtask

  task automatic test_repeat();
    int pulses;
    int last;
    pulses = 0;
    last = -1;
    repeat_mode = 1'b1;
    en = 1'b1;
    for (int t = 0; t <= 371; t++) begin
      step();
      if (done === 1'b1) begin
        pulses++;
        checks++;
        if ((last < 0 && t != 120) || (last >= 0 && t - last != 125)) begin
          failures++;
          $display("FAIL repeat_period t=%0d prev=%0d exp first=120 period=125", t, last);
        end
        last = t;
      end
      if (t >= 120 && t <= 124) begin
        checks++;
        if (txd !== 1'b1) begin
          failures++;
          $display("FAIL repeat_gap_txd t=%0d got=%b exp=1", t, txd);
        end
      end
      if (t == 125) begin
        checks++;
        if (txd !== 1'b0 || idx !== 2'd0 || word !== 8'h48) begin
          failures++;
          $display("FAIL repeat_restart got txd=%b idx=%0d word=%h exp 0 0 48", txd, idx, word);
        end
      end
      if (t == 122) begin
        checks++;
        if (ready !== 1'b1 || busy !== 1'b1) begin
          failures++;
          $display("FAIL repeat_gap_flags got rdy=%b busy=%b exp 1 1", ready, busy);
        end
      end
    end
    checks++;
    if (pulses != 3) begin
      failures++;
      $display("FAIL repeat_pulses got=%0d exp=3", pulses);
    end
  endtask

  task automatic test_gap_exit();
    checks++;
    if (busy !== 1'b1 || txd !== 1'b1) begin
      failures++;
      $display("FAIL gap_before_exit got busy=%b txd=%b exp 1 1", busy, txd);
    end
    en = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || txd !== 1'b1 || ready !== 1'b1 || idx !== 2'd0) begin
      failures++;
      $display("FAIL gap_exit got busy=%b txd=%b rdy=%b idx=%0d exp 0 1 1 0", busy, txd, ready, idx);
    end
    repeat (3) step();
    checks++;
    if (busy !== 1'b0 || txd !== 1'b1) begin
      failures++;
      $display("FAIL gap_exit_stays got busy=%b txd=%b exp 0 1", busy, txd);
    end
  endtask

  task automatic test_abort();
    int pulses;
    int hi_bad;
    pulses = 0;
    hi_bad = 0;
    repeat_mode = 1'b0;
    en = 1'b1;
    for (int t = 0; t <= 120; t++) begin
      step();
      if (t == 50) en = 1'b0;
      if (done === 1'b1) pulses++;
      if (t < 80 && t % 4 == 1) begin
        checks++;
        if (txd !== exp_bit(msg_tab[t / 40], (t % 40) / 4)) begin
          failures++;
          $display("FAIL abort_txd t=%0d got=%b exp=%b", t, txd, exp_bit(msg_tab[t / 40], (t % 40) / 4));
        end
      end
      if (t == 79) begin
        checks++;
        if (busy !== 1'b1 || idx !== 2'd1) begin
          failures++;
          $display("FAIL abort_last_stop got busy=%b idx=%0d exp 1 1", busy, idx);
        end
      end
      if (t == 80) begin
        checks++;
        if (busy !== 1'b0 || idx !== 2'd0 || ready !== 1'b1) begin
          failures++;
          $display("FAIL abort_idle got busy=%b idx=%0d rdy=%b exp 0 0 1", busy, idx, ready);
        end
      end
      if (t > 80 && txd !== 1'b1) hi_bad++;
    end
    checks++;
    if (pulses != 0 || hi_bad != 0) begin
      failures++;
      $display("FAIL abort_no_byte2 got pulses=%0d low_cycles=%0d exp 0 0", pulses, hi_bad);
    end
  endtask

  task automatic test_back_to_back();
    int pulses;
    int last;
    pulses = 0;
    last = 0;
    en1 = 1'b1;
    for (int t = 0; t <= 125; t++) begin
      step();
      if (done1 === 1'b1) begin
        pulses++;
        checks++;
        if (t - last != 40) begin
          failures++;
          $display("FAIL b2b_period t=%0d prev=%0d exp delta=40", t, last);
        end
        last = t;
      end
      if (t % 4 == 1) begin
        checks++;
        if (txd1 !== exp_bit(8'h41, (t % 40) / 4)) begin
          failures++;
          $display("FAIL b2b_txd t=%0d got=%b exp=%b", t, txd1, exp_bit(8'h41, (t % 40) / 4));
        end
      end
      if (t == 39 || t == 40) begin
        checks++;
        if (txd1 !== (t == 39) || busy1 !== 1'b1) begin
          failures++;
          $display("FAIL b2b_boundary t=%0d got txd=%b busy=%b exp txd=%b busy=1", t, txd1, busy1, t == 39);
        end
      end
    end
    checks++;
    if (pulses != 3) begin
      failures++;
      $display("FAIL b2b_pulses got=%0d exp=3", pulses);
    end
    en1 = 1'b0;
    repeat (45) step();
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_repeat();
    test_gap_exit();
    test_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/msg_uart_streamer.md
# msg_uart_streamer

Parametrised message transmitter for the board UART path. It holds a fixed ASCII message of `MSG_LEN` bytes and serialises it as 8N1 frames on `txd`, first byte first, using an internal bit-timed transmitter. It supports two modes: one-shot (one message per enable edge) and repeat (continuous, with a programmable idle gap between messages). It sits between the board switch/enable logic and the UART TX pin and replaces the fixed-string, fixed-gap sender.

## Interface
- `MSG_LEN`, 13: message length in bytes, ≥1.
- `MSG`, "Hello world!\n": `8*MSG_LEN`-bit message; byte 0 = `MSG[8*MSG_LEN-1 -: 8]`.
- `CLKS_PER_BIT`, 868: clock cycles per UART bit, ≥2.
- `GAP_CYCLES`, 95969: idle cycles (`txd`=1) between messages in repeat mode, ≥0.
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `en` in 1: transmit enable (level).
- `repeat_mode` in 1: 1 = continuous repeat, 0 = one-shot; sampled only in IDLE and at end of message.
- `txd` out 1: UART serial out, idle high.
- `word` out 8: byte currently being framed.
- `transmit_ready` out 1: high when no frame is in progress (IDLE or GAP).
- `busy` out 1: high in any state except IDLE.
- `msg_done` out 1: one-cycle pulse after the stop bit of the last byte.
- `char_idx` out `max(1,$clog2(MSG_LEN))`: index of `word` in the message.

## Operation
- Reset values: `txd`=1, `word`=0, `transmit_ready`=1, `busy`=0, `msg_done`=0, `char_idx`=0, FSM=IDLE. Reset asserted mid-frame forces `txd` high immediately, without waiting for the clock.
- FSM states: IDLE, START, DATA, STOP, GAP.
- IDLE:
  - Repeat mode: start when `en`=1.
  - One-shot mode: start only on a 0→1 edge of registered `en` (edge history reset to 0).
  - Start action: `char_idx`=0, `word`=byte 0, go to START.
- START: `txd`=0 for `CLKS_PER_BIT` cycles, then DATA.
- DATA: 8 bits of `word`, LSB first, `CLKS_PER_BIT` cycles each; 3-bit counter. Then STOP.
- STOP: `txd`=1 for `CLKS_PER_BIT` cycles. At the end of STOP:
  - `en`=0: go to IDLE, `char_idx`=0, no `msg_done` (abort at byte boundary; a frame is never truncated).
  - `char_idx` < `MSG_LEN`-1: increment `char_idx`, load the next byte into `word`, go to START (back-to-back frames, no idle bit).
  - Last byte: pulse `msg_done`, `char_idx`=0. Then:
    - `repeat_mode`=1 and `en`=1: go to GAP, or straight to START with byte 0 if `GAP_CYCLES`=0.
    - Otherwise: go to IDLE.
- GAP: `txd`=1 for `GAP_CYCLES` cycles, then START with byte 0. If `en`=0 at any GAP cycle, go to IDLE on the next edge.
- Bit timer: counter 0..`CLKS_PER_BIT`-1, sized `$clog2(CLKS_PER_BIT)`, wraps to 0 on every state/bit change. The gap counter is sized `$clog2(GAP_CYCLES+1)`.
- `word` holds its value through IDLE after a message (last byte sent, or 0 after reset).

## Timing
- Start latency: `en` sampled high at edge k in IDLE (edge-qualified in one-shot) → `txd`=0 from edge k.
- Frame length is exactly 10·`CLKS_PER_BIT` cycles; start of byte n+1 = start of byte n + 10·`CLKS_PER_BIT`.
- Message length is `MSG_LEN`·10·`CLKS_PER_BIT` cycles from first start-bit edge to the `msg_done` edge.
- Repeat period = `MSG_LEN`·10·`CLKS_PER_BIT` + `GAP_CYCLES` cycles.
- `msg_done` is high for exactly the one cycle following the last STOP.
- `transmit_ready` falls on the edge entering START and rises on the edge leaving STOP to IDLE or GAP.

## Test plan
Bench parameters: `CLKS_PER_BIT`=4, `MSG`="Hi\n", `MSG_LEN`=3, `GAP_CYCLES`=5.

- Reset: hold `rst`=0 mid-DATA → `txd`=1 asynchronously, all outputs at reset values; release with `en`=0 → stays IDLE.
- One-shot: `repeat_mode`=0, raise `en` and hold → frames 0x48, 0x69, 0x0A sent LSB first (bit pattern checked every 4 cycles); `msg_done` pulses once at cycle 120; no further frames until `en` falls and rises again.
- Repeat: `repeat_mode`=1, `en`=1 → `msg_done` pulses every 125 cycles; `txd`=1 for exactly 5 cycles between the last stop bit and the next start bit.
- Abort: drop `en` during DATA of byte 1 → byte 1 frame completes, then IDLE, `char_idx`=0, no `msg_done`; byte 2 is never sent.
- Gap exit: drop `en` during GAP → IDLE the next cycle, `busy`=0, `txd`=1.
- Edge case: `MSG_LEN`=1, `GAP_CYCLES`=0 → consecutive frames back-to-back, `msg_done` every 40 cycles.
